// File: rtl/alu_param_pkg.sv
// alu_param_pkg -- shared definitions for the parameterised ALU.
//   Opcode constants for the 4-bit opt field and the controller state
//   encoding used by alu_param.
package alu_param_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROTL = 4'h6;
    localparam logic [3:0] OP_ROTR = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_NOT  = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_div_seq.sv
// alu_div_seq -- iterative restoring divider, one quotient bit per cycle.
//   clk, reset (async, active-low)
//   start     : load a/b and perform the first iteration on this edge
//   a, b      : dividend / divisor (b must be nonzero; the caller filters b == 0)
//   done      : one-cycle pulse, quotient/remainder valid while it is high
//   quotient, remainder : results
// Latency: start edge plus W-1 further edges of iteration; done is high
// in the cycle after the last iteration, i.e. W cycles after start.
module alu_div_seq
    import alu_param_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, quo_q, div_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    logic [W-1:0]  src_rem, src_quo, src_div;
    logic [W:0]    shifted, trial;
    logic          ge;
    logic [W-1:0]  rem_nx, quo_nx;

    // The first iteration runs straight off the input operands so the
    // start edge already does useful work.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? a  : quo_q;
        src_div = start ? b  : div_q;
        shifted = {src_rem, src_quo[W-1]};
        trial   = shifted - {1'b0, src_div};
        ge      = ~trial[W];
        rem_nx  = ge ? trial[W-1:0] : shifted[W-1:0];
        quo_nx  = {src_quo[W-2:0], ge};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            rem_q  <= rem_nx;
            quo_q  <= quo_nx;
            div_q  <= b;
            cnt_q  <= CW'(W - 1);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q  <= rem_nx;
            quo_q  <= quo_nx;
            cnt_q  <= cnt_q - CW'(1);
            done_q <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_param.sv
// alu_param -- parameterised ALU with valid/ready handshake and an
// optional iterative divider.
//   clk, reset (async, active-low)
//   in_valid / in_ready   : request handshake, opt/A/B taken on accept
//   out_valid / out_ready : result handshake, Res/flags held until taken
//   Res (2W)              : result; carry, zero, err flags
// Parameters: W operand width (4..32), DIV_EN enables opcode 3.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for a request, in_ready high
// DIV     | divider iterating, result not yet available
// DONE    | Res/flags valid, out_valid high until out_ready
module alu_param
    import alu_param_pkg::*;
#(
    parameter int W      = 8,
    parameter bit DIV_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     opt,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] Res,
    output logic           carry,
    output logic           zero,
    output logic           err
);

    alu_state_t state_q, state_d;

    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] calc_res;
    logic           calc_carry, calc_err;
    logic           start_div;

    logic [2*W-1:0] res_d, res_q;
    logic           carry_d, err_d;
    logic           carry_q, zero_q, err_q;
    logic           load_res;
    logic           div_start;

    logic           div_done;
    logic [W-1:0]   div_quo, div_rem;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign prod = {{W{1'b0}}, A} * {{W{1'b0}}, B};

    // Single-cycle result for whatever is on the inputs; only captured
    // on an accept edge.
    always_comb begin
        calc_res   = '0;
        calc_carry = 1'b0;
        calc_err   = 1'b0;
        case (opt)
            OP_ADD: begin
                calc_res   = {{(W-1){1'b0}}, sum};
                calc_carry = sum[W];
            end
            OP_SUB: begin
                calc_res   = {{W{1'b0}}, A - B};
                calc_carry = (A < B);
            end
            OP_MUL:  calc_res = prod;
            OP_DIV: begin
                // Only the faulting cases land here; a real divide goes
                // through the DIV state instead.
                if (!DIV_EN) begin
                    calc_err = 1'b1;
                end else if (B == '0) begin
                    calc_res = '1;
                    calc_err = 1'b1;
                end
            end
            OP_SHL:  calc_res = {{W{1'b0}}, A[W-2:0], 1'b0};
            OP_SHR:  calc_res = {{W{1'b0}}, 1'b0, A[W-1:1]};
            OP_ROTL: calc_res = {{W{1'b0}}, A[W-2:0], A[W-1]};
            OP_ROTR: calc_res = {{W{1'b0}}, A[0], A[W-1:1]};
            OP_AND:  calc_res = {{W{1'b0}}, A & B};
            OP_OR:   calc_res = {{W{1'b0}}, A | B};
            OP_XOR:  calc_res = {{W{1'b0}}, A ^ B};
            OP_NOR:  calc_res = {{W{1'b0}}, ~(A | B)};
            OP_NAND: calc_res = {{W{1'b0}}, ~(A & B)};
            OP_XNOR: calc_res = {{W{1'b0}}, ~(A ^ B)};
            OP_NOT:  calc_res = {{W{1'b0}}, ~A};
            default: calc_err = 1'b1;
        endcase
    end

    assign start_div = DIV_EN && (opt == OP_DIV) && (B != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_res  = 1'b0;
        div_start = 1'b0;
        res_d     = calc_res;
        carry_d   = calc_carry;
        err_d     = calc_err;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (start_div) begin
                        state_d   = ST_DIV;
                        div_start = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        load_res = 1'b1;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d  = ST_DONE;
                    load_res = 1'b1;
                    res_d    = {div_rem, div_quo};
                    carry_d  = 1'b0;
                    err_d    = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // zero is registered alongside Res so that reset can force it low
    // even though Res is also cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (load_res) begin
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= (res_d == '0);
            err_q   <= err_d;
        end
    end

    generate
        if (DIV_EN) begin : g_div
            alu_div_seq #(.W(W)) u_div (
                .clk       (clk),
                .reset     (reset),
                .start     (div_start),
                .a         (A),
                .b         (B),
                .done      (div_done),
                .quotient  (div_quo),
                .remainder (div_rem)
            );
        end else begin : g_nodiv
            assign div_done = 1'b0;
            assign div_quo  = '0;
            assign div_rem  = '0;
        end
    endgenerate

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Res       = res_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_param.sv
module tb_alu_param;
    import alu_param_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    logic        in_valid8, out_ready8, in_ready8, out_valid8;
    logic [3:0]  opt8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        carry8, zero8, err8;

    logic        in_valid4, out_ready4, in_ready4, out_valid4;
    logic [3:0]  opt4;
    logic [3:0]  a4, b4;
    logic [7:0]  res4;
    logic        carry4, zero4, err4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_param #(.W(8), .DIV_EN(1'b1)) dut8 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .opt(opt8), .A(a8), .B(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .Res(res8), .carry(carry8), .zero(zero8), .err(err8)
    );

    alu_param #(.W(4), .DIV_EN(1'b1)) dut4 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .opt(opt4), .A(a4), .B(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .Res(res4), .carry(carry4), .zero(zero4), .err(err4)
    );

    // Present one request for one edge, then scramble the inputs so a
    // design that fails to register them shows wrong results.
    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid8 = 1'b1; opt8 = op; a8 = a; b8 = b;
        @(posedge clk); #1;
        in_valid8 = 1'b0; opt8 = OP_XOR; a8 = 8'hAA; b8 = 8'h55;
    endtask

    task automatic take8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (res8 !== 16'h0000) begin fails++; $display("FAIL reset_res: got %h want 0000", res8); end
        tests++; if (carry8 !== 1'b0) begin fails++; $display("FAIL reset_carry: got %b want 0", carry8); end
        tests++; if (zero8 !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b want 0", zero8); end
        tests++; if (err8 !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err8); end
        tests++; if (out_valid8 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid8); end
        tests++; if (in_ready8 !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready8); end
    endtask

    task automatic test_add_sub();
        issue8(OP_ADD, 8'hFF, 8'h01);
        tests++; if (out_valid8 !== 1'b1) begin fails++; $display("FAIL add_latency: out_valid got %b want 1", out_valid8); end
        tests++; if (in_ready8 !== 1'b0) begin fails++; $display("FAIL add_in_ready: got %b want 0", in_ready8); end
        tests++; if (res8 !== 16'h0100) begin fails++; $display("FAIL add_res: got %h want 0100", res8); end
        tests++; if (carry8 !== 1'b1) begin fails++; $display("FAIL add_carry: got %b want 1", carry8); end
        tests++; if (zero8 !== 1'b0) begin fails++; $display("FAIL add_zero: got %b want 0", zero8); end
        take8();
        tests++; if (in_ready8 !== 1'b1) begin fails++; $display("FAIL add_back_idle: in_ready got %b want 1", in_ready8); end

        issue8(OP_SUB, 8'h02, 8'h06);
        tests++; if (res8 !== 16'h00FC) begin fails++; $display("FAIL sub_res: got %h want 00FC", res8); end
        tests++; if (carry8 !== 1'b1) begin fails++; $display("FAIL sub_borrow: got %b want 1", carry8); end
        tests++; if (err8 !== 1'b0) begin fails++; $display("FAIL sub_err: got %b want 0", err8); end
        take8();

        issue8(OP_SUB, 8'h06, 8'h02);
        tests++; if (res8 !== 16'h0004) begin fails++; $display("FAIL sub2_res: got %h want 0004", res8); end
        tests++; if (carry8 !== 1'b0) begin fails++; $display("FAIL sub2_borrow: got %b want 0", carry8); end
        take8();
    endtask

    task automatic test_single_cycle_ops();
        logic [3:0]  ops  [15] = '{OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_AND, OP_OR, OP_XOR,
                                   OP_NOR, OP_NAND, OP_XNOR, OP_NOT, OP_AND, OP_MUL, OP_MUL, OP_ADD};
        logic [7:0]  av   [15] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'hF0, 8'hF0, 8'hF0,
                                   8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hFF, 8'h10, 8'h12};
        logic [7:0]  bv   [15] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C,
                                   8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h0F, 8'hFF, 8'h10, 8'h34};
        logic [15:0] want [15] = '{16'h0002, 16'h0040, 16'h0003, 16'h00C0, 16'h0030, 16'h00FC, 16'h00CC,
                                   16'h0003, 16'h00CF, 16'h0033, 16'h000F, 16'h0000, 16'hFE01, 16'h0100, 16'h0046};
        for (int i = 0; i < 15; i++) begin
            issue8(ops[i], av[i], bv[i]);
            tests++; if (out_valid8 !== 1'b1) begin fails++; $display("FAIL op%0d_latency: op %h out_valid got %b want 1", i, ops[i], out_valid8); end
            tests++; if (res8 !== want[i]) begin fails++; $display("FAIL op%0d_res: op %h got %h want %h", i, ops[i], res8, want[i]); end
            tests++; if (carry8 !== 1'b0) begin fails++; $display("FAIL op%0d_carry: op %h got %b want 0", i, ops[i], carry8); end
            tests++; if (err8 !== 1'b0) begin fails++; $display("FAIL op%0d_err: op %h got %b want 0", i, ops[i], err8); end
            tests++; if (zero8 !== (want[i] == 16'h0000)) begin fails++; $display("FAIL op%0d_zero: op %h got %b want %b", i, ops[i], zero8, want[i] == 16'h0000); end
            take8();
        end
    endtask

    task automatic test_div();
        logic [7:0]  da   [2] = '{8'd200, 8'hFF};
        logic [7:0]  db   [2] = '{8'd7,   8'h10};
        logic [15:0] want [2] = '{16'h041C, 16'h0F0F};
        int cyc;
        bit rdy_seen;
        for (int i = 0; i < 2; i++) begin
            issue8(OP_DIV, da[i], db[i]);
            cyc = 1;
            rdy_seen = 1'b0;
            while (out_valid8 !== 1'b1 && cyc < 40) begin
                if (in_ready8 !== 1'b0) rdy_seen = 1'b1;
                @(posedge clk); #1;
                cyc++;
            end
            tests++; if (cyc != 9) begin fails++; $display("FAIL div%0d_latency: got %0d cycles want 9", i, cyc); end
            tests++; if (rdy_seen) begin fails++; $display("FAIL div%0d_in_ready: got 1 during DIV want 0", i); end
            tests++; if (in_ready8 !== 1'b0) begin fails++; $display("FAIL div%0d_done_in_ready: got %b want 0", i, in_ready8); end
            tests++; if (res8 !== want[i]) begin fails++; $display("FAIL div%0d_res: got %h want %h", i, res8, want[i]); end
            tests++; if (err8 !== 1'b0) begin fails++; $display("FAIL div%0d_err: got %b want 0", i, err8); end
            tests++; if (carry8 !== 1'b0) begin fails++; $display("FAIL div%0d_carry: got %b want 0", i, carry8); end
            take8();
        end
    endtask

    task automatic test_div_zero_illegal();
        issue8(OP_DIV, 8'h05, 8'h00);
        tests++; if (out_valid8 !== 1'b1) begin fails++; $display("FAIL divz_latency: out_valid got %b want 1", out_valid8); end
        tests++; if (res8 !== 16'hFFFF) begin fails++; $display("FAIL divz_res: got %h want FFFF", res8); end
        tests++; if (err8 !== 1'b1) begin fails++; $display("FAIL divz_err: got %b want 1", err8); end
        tests++; if (zero8 !== 1'b0) begin fails++; $display("FAIL divz_zero: got %b want 0", zero8); end
        take8();

        issue8(OP_ILL, 8'h12, 8'h34);
        tests++; if (out_valid8 !== 1'b1) begin fails++; $display("FAIL ill_latency: out_valid got %b want 1", out_valid8); end
        tests++; if (res8 !== 16'h0000) begin fails++; $display("FAIL ill_res: got %h want 0000", res8); end
        tests++; if (err8 !== 1'b1) begin fails++; $display("FAIL ill_err: got %b want 1", err8); end
        tests++; if (zero8 !== 1'b1) begin fails++; $display("FAIL ill_zero: got %b want 1", zero8); end
        take8();
    endtask

    task automatic test_hold_w4();
        in_valid4 = 1'b1; opt4 = OP_MUL; a4 = 4'hF; b4 = 4'hF;
        @(posedge clk); #1;
        // keep a different request pending while DONE must refuse it
        opt4 = OP_ADD; a4 = 4'h1; b4 = 4'h2;
        for (int i = 0; i < 5; i++) begin
            tests++; if (out_valid4 !== 1'b1) begin fails++; $display("FAIL hold%0d_out_valid: got %b want 1", i, out_valid4); end
            tests++; if (res4 !== 8'hE1) begin fails++; $display("FAIL hold%0d_res: got %h want E1", i, res4); end
            tests++; if (in_ready4 !== 1'b0) begin fails++; $display("FAIL hold%0d_in_ready: got %b want 0", i, in_ready4); end
            @(posedge clk); #1;
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        tests++; if (out_valid4 !== 1'b0) begin fails++; $display("FAIL hold_release_out_valid: got %b want 0", out_valid4); end
        tests++; if (in_ready4 !== 1'b1) begin fails++; $display("FAIL hold_release_in_ready: got %b want 1", in_ready4); end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        tests++; if (out_valid4 !== 1'b1) begin fails++; $display("FAIL hold_next_out_valid: got %b want 1", out_valid4); end
        tests++; if (res4 !== 8'h03) begin fails++; $display("FAIL hold_next_res: got %h want 03", res4); end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    task automatic test_reset_during_div();
        bit valid_seen;
        issue8(OP_DIV, 8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (res8 !== 16'h0000) begin fails++; $display("FAIL rst_div_res: got %h want 0000", res8); end
        tests++; if (err8 !== 1'b0) begin fails++; $display("FAIL rst_div_err: got %b want 0", err8); end
        tests++; if (zero8 !== 1'b0) begin fails++; $display("FAIL rst_div_zero: got %b want 0", zero8); end
        tests++; if (carry8 !== 1'b0) begin fails++; $display("FAIL rst_div_carry: got %b want 0", carry8); end
        tests++; if (out_valid8 !== 1'b0) begin fails++; $display("FAIL rst_div_out_valid: got %b want 0", out_valid8); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++; if (in_ready8 !== 1'b1) begin fails++; $display("FAIL rst_div_in_ready: got %b want 1", in_ready8); end
        valid_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid8 !== 1'b0) valid_seen = 1'b1;
        end
        tests++; if (valid_seen) begin fails++; $display("FAIL rst_div_abort: out_valid got 1 want 0"); end
        issue8(OP_ADD, 8'h02, 8'h03);
        tests++; if (out_valid8 !== 1'b1) begin fails++; $display("FAIL rst_add_latency: out_valid got %b want 1", out_valid8); end
        tests++; if (res8 !== 16'h0005) begin fails++; $display("FAIL rst_add_res: got %h want 0005", res8); end
        tests++; if (carry8 !== 1'b0) begin fails++; $display("FAIL rst_add_carry: got %b want 0", carry8); end
        take8();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; opt8 = 4'h0; a8 = 8'h00; b8 = 8'h00;
        in_valid4 = 1'b0; out_ready4 = 1'b0; opt4 = 4'h0; a4 = 4'h0; b4 = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_add_sub();
        test_single_cycle_ops();
        test_div();
        test_div_zero_illegal();
        test_hold_w4();
        test_reset_during_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/alu_param.md
ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 Parameter W, 8, operand width in bits (legal 4..32).
REQ-002 Parameter DIV_EN, 1, 1 = iterative divider present; 0 = opcode 3 treated as illegal.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 opt  input  4  opcode.
REQ-008 A  input  W  operand A.
REQ-009 B  input  W  operand B.
REQ-010 out_valid  output  1  Res/flags hold a completed result.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 Res  output  2W  result.
REQ-013 carry  output  1  add carry-out / subtract borrow.
REQ-014 zero  output  1  Res equals 0.
REQ-015 err  output  1  divide-by-zero or illegal opcode.

Function
REQ-016 The block SHALL implement FSM states IDLE, DIV and DONE; in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-017 The block SHALL accept a request on a cycle with in_valid && in_ready, registering opt, A and B at that edge; later input changes SHALL be ignored until the next accept.
REQ-018 Non-divide opcodes SHALL complete in one cycle: IDLE -> DONE at the accept edge, so out_valid is high on the following cycle.
REQ-019 Divide with B != 0 SHALL go IDLE -> DIV, iterate exactly W cycles, then enter DONE, so out_valid rises W+1 cycles after accept.
REQ-020 Divide with B == 0 SHALL go directly to DONE with Res = all ones and err = 1.
REQ-021 DONE SHALL hold Res and flags stable until out_ready = 1, then return to IDLE; there is no accept while in DONE.
REQ-022 The opcodes SHALL be: 0 add; 1 sub; 2 mul; 3 div; 4 shl1; 5 shr1 (logical); 6 rotl1; 7 rotr1; 8 and; 9 or; a xor; b nor; c nand; d xnor; e not A.
REQ-023 The width rules SHALL be:
- add: Res = zero-extended (W+1)-bit sum, carry = sum bit W.
- sub: Res[W-1:0] = (A-B) mod 2^W, carry = (A<B).
- mul: Res = full 2W unsigned product.
- div: Res = {remainder, quotient}.
- shifts and rotates: applied within W bits.
- all other opcodes: Res[2W-1:W] = 0.
REQ-024 For opcode f, and opcode 3 when DIV_EN = 0, the block SHALL produce Res = 0 and err = 1 with single-cycle latency.
REQ-025 zero SHALL reflect the registered Res, and carry SHALL be 0 for all opcodes except add and sub.
REQ-026 err SHALL be 0 for all legal, non-faulting operations.

Reset
REQ-027 reset low SHALL immediately force IDLE, Res = 0, carry = 0, zero = 0, err = 0, out_valid = 0 and the divider counter to 0.
REQ-028 Reset asserted during DIV or DONE SHALL abort the operation with no result delivered, and in_ready SHALL be 1 on the first cycle after release.

Structure
REQ-029 Package alu_param_pkg SHALL hold the opcode constants and the FSM state encoding.
REQ-030 The iterative restoring divider SHALL be sub-module alu_div_seq (start, done, quotient, remainder; W-cycle latency), instantiated only when DIV_EN = 1.

Verification
REQ-031 W=8, add A=FF, B=01, out_ready=1 -> out_valid the cycle after accept, Res=0100, carry=1, zero=0.
REQ-032 W=8, sub A=02, B=06 -> Res=00FC, carry=1, err=0.
REQ-033 W=8, div A=200, B=7 -> out_valid exactly 9 cycles after accept, Res={4, 28}=041C, and in_ready=0 throughout.
REQ-034 W=8, div A=5, B=0 -> next cycle Res=FFFF, err=1; then opcode f -> Res=0, err=1, zero=1.
REQ-035 W=4, mul A=F, B=F with out_ready low for 5 cycles -> Res=E1 held stable with out_valid high, and no accept despite in_valid=1.
REQ-036 W=8, div accepted, reset pulsed low at cycle 4 -> all outputs 0 immediately, in_ready=1 after release, and the next add 02+03 returns 0005.
